mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit in the execute stage, beside the ALU.
- Consumes the same srcA/srcB operands the ALU receives. Owns the HI/LO registers.
- Drives busy to the hazard unit; hi/lo feed the execute-stage result mux for mfhi/mflo.
- Fixed-latency, non-pipelined: one operation in flight at a time.

Parameters:
- MULT_CYCLES, 5: cycles busy stays high for mult/multu (must be >=1).
- DIV_CYCLES, 10: cycles busy stays high for div/divu (must be >=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (reset==0 at a clk edge resets).
- start  input  1  one-cycle request; op, srcA and srcB are sampled when start is high.
- mdOp  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6/7 see Optional Feature.
- srcA  input  32  operand rs.
- srcB  input  32  operand rt.
- busy  output  1  operation in progress.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset, at a clk edge with reset==0:
  - busy=0, hi=0, lo=0, counter=0, state=IDLE.
  - Any in-flight operation is discarded. Reset has priority over start.
- States: IDLE, RUN.
- IDLE, start=1, mdOp in {0..3}:
  - Latch the result of srcA op srcB into internal tempHi/tempLo.
  - Load counter with MULT_CYCLES or DIV_CYCLES; go to RUN; busy=1 from the next cycle.
- IDLE, start=1, mdOp=4 (mthi): hi<=srcA at this edge. No busy; stays IDLE.
- IDLE, start=1, mdOp=5 (mtlo): lo<=srcA at this edge. No busy; stays IDLE.
- IDLE, start=1, mdOp=6/7 with the macro undefined, or mdOp unused: ignored, no state change.
- RUN:
  - Counter decrements each cycle.
  - In the cycle counter==1: at the edge, hi<=tempHi, lo<=tempLo, busy<=0, go to IDLE.
  - So busy is high for exactly N cycles, and hi/lo change exactly N cycles after the start edge.
  - hi/lo keep their old values while busy=1.
- start while busy=1: ignored. The hazard unit must stall; the block does not queue requests.
- mult: signed 32x32 -> 64, {hi,lo}=product.
- multu: unsigned 32x32 -> 64, {hi,lo}=product.
- div/divu: lo=quotient, hi=remainder.
  - Signed division truncates toward zero; remainder takes the sign of the dividend.
- Divide by zero (srcB==0): busy cycle runs normally, but hi/lo are left unchanged at completion.
- div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. Wraps, no trap.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - mdOp=6 (madd): {hi,lo} <= {hi,lo} + signed(srcA*srcB).
  - mdOp=7 (maddu): the same with an unsigned product.
  - Both run with MULT_CYCLES latency. Accumulation is modulo 2^64.
  - The accumulate base is hi/lo as sampled at the start edge.
- Undefined: mdOp 6/7 are ignored like any unused code. No accumulate logic is built.

Decomposition:
- Shared package mdu_pkg holds:
  - mdOp encodings MD_MULT..MD_MADDU.
  - State encoding IDLE/RUN.
  - Default latency constants.
- No sub-module: the result computation, counter and FSM fit in one module.
- The ALU's aluOp encoding is unaffected.

Test Plan:
- Reset behaviour: reset=0 for 2 cycles -> busy=0, hi=0, lo=0. Assert reset=0 mid-div -> next edge busy=0, hi/lo=0, no later update.
- Signed mult: start mult, srcA=0xFFFFFFFE (-2), srcB=3 -> busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Signed div: start div, srcA=0xFFFFFFF9 (-7), srcB=2 -> after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1.
- Boundary divides: divide by zero with hi=0x11, lo=0x22 preset -> after 10 cycles hi=0x11, lo=0x22. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Moves and overlap: mthi 0xDEADBEEF -> hi updates next edge, busy stays 0. A second start issued during a mult's busy window -> ignored, first result is intact.
- Accumulate (MDU_MADD_EN only): hi=0, lo=0xFFFFFFFF, maddu 1*1 -> hi=1, lo=0. Without the macro, mdOp=6 leaves busy=0 and hi/lo unchanged.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes, FSM
// states, default latencies and the divide helper.
// The optional madd/maddu accumulate operations are enabled by MDU_MADD_EN.
package mdu_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5,
        MD_MADD  = 3'd6,
        MD_MADDU = 3'd7
    } mdOp_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_MULT_CYCLES = 5;
    localparam int DEFAULT_DIV_CYCLES  = 10;

    // Returns {remainder, quotient}. Signed mode divides the magnitudes and
    // re-applies the signs so the quotient truncates toward zero and the
    // remainder follows the dividend. This also makes 0x80000000 / -1 wrap
    // to 0x80000000 with no special case. A zero divisor is replaced by one
    // so the datapath stays defined; the caller discards that result.
    function automatic logic [63:0] divideOp(input logic [31:0] dividend,
                                             input logic [31:0] divisor,
                                             input logic        isSigned);
        logic [31:0] magA;
        logic [31:0] magB;
        logic [31:0] quo;
        logic [31:0] rem;
        logic        negQuo;
        logic        negRem;
        negRem = isSigned & dividend[31];
        negQuo = isSigned & (dividend[31] ^ divisor[31]);
        magA   = negRem ? (~dividend + 32'd1) : dividend;
        magB   = (isSigned & divisor[31]) ? (~divisor + 32'd1) : divisor;
        if (magB == 32'd0) begin
            magB = 32'd1;
        end
        quo = magA / magB;
        rem = magA % magB;
        if (negQuo) begin
            quo = ~quo + 32'd1;
        end
        if (negRem) begin
            rem = ~rem + 32'd1;
        end
        return {rem, quo};
    endfunction

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit beside the ALU. Owns HI/LO, holds busy for a fixed
// number of cycles per operation, and commits the result when busy drops.
// Optional feature macro: MDU_MADD_EN (madd/maddu accumulate into HI/LO).
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEFAULT_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEFAULT_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    state_t           state;
    logic [CNT_W-1:0] counter;
    logic [31:0]      tempHi;
    logic [31:0]      tempLo;
    logic             tempWrite;

    logic [63:0]      prodSigned;
    logic [63:0]      prodUnsigned;
    logic [63:0]      opResult;
    logic             opWrites;
    logic             opLaunch;
    logic [CNT_W-1:0] opCycles;

    // Full 64-bit products from sign- or zero-extended operands; the low
    // 64 bits of the extended product are exactly the 32x32 result.
    always_comb begin
        prodSigned   = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        prodUnsigned = {32'd0, srcA} * {32'd0, srcB};
    end

    // Decode the requested operation into its result, latency and whether
    // the result should be committed to HI/LO when the op finishes.
    always_comb begin
        opResult = 64'd0;
        opWrites = 1'b0;
        opLaunch = 1'b0;
        opCycles = '0;
        case (mdOp)
            MD_MULT: begin
                opResult = prodSigned;
                opWrites = 1'b1;
                opLaunch = 1'b1;
                opCycles = CNT_W'(MULT_CYCLES);
            end
            MD_MULTU: begin
                opResult = prodUnsigned;
                opWrites = 1'b1;
                opLaunch = 1'b1;
                opCycles = CNT_W'(MULT_CYCLES);
            end
            MD_DIV: begin
                opResult = divideOp(srcA, srcB, 1'b1);
                opWrites = (srcB != 32'd0);
                opLaunch = 1'b1;
                opCycles = CNT_W'(DIV_CYCLES);
            end
            MD_DIVU: begin
                opResult = divideOp(srcA, srcB, 1'b0);
                opWrites = (srcB != 32'd0);
                opLaunch = 1'b1;
                opCycles = CNT_W'(DIV_CYCLES);
            end
`ifdef MDU_MADD_EN
            MD_MADD: begin
                opResult = {hi, lo} + prodSigned;
                opWrites = 1'b1;
                opLaunch = 1'b1;
                opCycles = CNT_W'(MULT_CYCLES);
            end
            MD_MADDU: begin
                opResult = {hi, lo} + prodUnsigned;
                opWrites = 1'b1;
                opLaunch = 1'b1;
                opCycles = CNT_W'(MULT_CYCLES);
            end
`endif
            default: begin
            end
        endcase
    end

    // Control FSM: accept a request in IDLE, count down in RUN, and commit
    // the latched result to HI/LO on the final busy cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            hi        <= 32'd0;
            lo        <= 32'd0;
            counter   <= '0;
            tempHi    <= 32'd0;
            tempLo    <= 32'd0;
            tempWrite <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (opLaunch) begin
                            tempHi    <= opResult[63:32];
                            tempLo    <= opResult[31:0];
                            tempWrite <= opWrites;
                            counter   <= opCycles;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else if (mdOp == MD_MTHI) begin
                            hi <= srcA;
                        end else if (mdOp == MD_MTLO) begin
                            lo <= srcA;
                        end
                    end
                end
                RUN: begin
                    if (counter == CNT_W'(1)) begin
                        if (tempWrite) begin
                            hi <= tempHi;
                            lo <= tempLo;
                        end
                        busy    <= 1'b0;
                        counter <= '0;
                        state   <= IDLE;
                    end else begin
                        counter <= counter - CNT_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus randomized operations
// compared against an arithmetic reference model of HI/LO and latency.
// Build with MDU_MADD_EN defined to exercise madd/maddu.
module tb_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdOp;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdOp  (mdOp),
        .srcA  (srcA),
        .srcB  (srcB),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    // Drive a one-cycle start request; returns #1 after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        mdOp  = op;
        srcA  = a;
        srcB  = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count busy cycles (bounded) and note whether HI/LO moved off the
    // pre-operation model values while busy was high.
    task automatic waitIdle(output int n, output logic stable);
        n      = 0;
        stable = 1'b1;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (hi !== modelHi || lo !== modelLo) stable = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: expected HI/LO after an op and its busy length,
    // computed with 64-bit integer arithmetic.
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eh, output logic [31:0] el, output int cyc);
        longint          sa;
        longint          sb;
        longint          sp;
        longint          q;
        longint          r;
        longint unsigned ua;
        longint unsigned ub;
        longint unsigned up;
        logic   [63:0]   acc;
        sa  = longint'(signed'(a));
        sb  = longint'(signed'(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        eh  = modelHi;
        el  = modelLo;
        cyc = 0;
        acc = 64'd0;
        case (op)
            3'd0: begin sp = sa * sb; {eh, el} = sp; cyc = MULT_N; end
            3'd1: begin up = ua * ub; {eh, el} = up; cyc = MULT_N; end
            3'd2: begin
                cyc = DIV_N;
                if (b != 32'd0) begin
                    q = sa / sb;
                    r = sa % sb;
                    el = q[31:0];
                    eh = r[31:0];
                end
            end
            3'd3: begin
                cyc = DIV_N;
                if (b != 32'd0) begin
                    el = a / b;
                    eh = a % b;
                end
            end
            3'd4: eh = a;
            3'd5: el = a;
`ifdef MDU_MADD_EN
            3'd6: begin sp = sa * sb; acc = {modelHi, modelLo} + sp; {eh, el} = acc; cyc = MULT_N; end
            3'd7: begin up = ua * ub; acc = {modelHi, modelLo} + up; {eh, el} = acc; cyc = MULT_N; end
`endif
            default: begin end
        endcase
    endtask

    task automatic test_reset();
        reset = 1'b0;
        start = 1'b0;
        mdOp  = 3'd0;
        srcA  = 32'd0;
        srcB  = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL reset_hi: got %h expected 0", hi); end
        checks++; if (lo !== 32'd0) begin errors++; $display("[TB] FAIL reset_lo: got %h expected 0", lo); end
        @(negedge clk);
        reset   = 1'b1;
        modelHi = 32'd0;
        modelLo = 32'd0;
    endtask

    task automatic test_mult();
        logic [2:0]  ops [2] = '{3'd0, 3'd1};
        logic [31:0] eHi [2] = '{32'hFFFFFFFF, 32'h00000002};
        logic [31:0] eLo [2] = '{32'hFFFFFFFA, 32'hFFFFFFFA};
        int          n;
        logic        stable;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 32'hFFFFFFFE, 32'd3);
            waitIdle(n, stable);
            checks++; if (n != MULT_N) begin errors++; $display("[TB] FAIL mult_cycles[%0d]: got %0d expected %0d", i, n, MULT_N); end
            checks++; if (!stable) begin errors++; $display("[TB] FAIL mult_hold[%0d]: hi/lo changed while busy, expected held %h/%h", i, modelHi, modelLo); end
            checks++; if (hi !== eHi[i]) begin errors++; $display("[TB] FAIL mult_hi[%0d]: got %h expected %h", i, hi, eHi[i]); end
            checks++; if (lo !== eLo[i]) begin errors++; $display("[TB] FAIL mult_lo[%0d]: got %h expected %h", i, lo, eLo[i]); end
            modelHi = eHi[i];
            modelLo = eLo[i];
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [2] = '{3'd2, 3'd3};
        logic [31:0] aIn [2] = '{32'hFFFFFFF9, 32'd7};
        logic [31:0] eHi [2] = '{32'hFFFFFFFF, 32'd1};
        logic [31:0] eLo [2] = '{32'hFFFFFFFD, 32'd3};
        int          n;
        logic        stable;
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], aIn[i], 32'd2);
            waitIdle(n, stable);
            checks++; if (n != DIV_N) begin errors++; $display("[TB] FAIL div_cycles[%0d]: got %0d expected %0d", i, n, DIV_N); end
            checks++; if (!stable) begin errors++; $display("[TB] FAIL div_hold[%0d]: hi/lo changed while busy, expected held %h/%h", i, modelHi, modelLo); end
            checks++; if (hi !== eHi[i]) begin errors++; $display("[TB] FAIL div_hi[%0d]: got %h expected %h", i, hi, eHi[i]); end
            checks++; if (lo !== eLo[i]) begin errors++; $display("[TB] FAIL div_lo[%0d]: got %h expected %h", i, lo, eLo[i]); end
            modelHi = eHi[i];
            modelLo = eLo[i];
        end
    endtask

    task automatic test_boundary_div();
        int   n;
        logic stable;
        issue(3'd4, 32'h11, 32'd0);
        issue(3'd5, 32'h22, 32'd0);
        modelHi = 32'h11;
        modelLo = 32'h22;
        issue(3'd2, 32'h1234, 32'd0);
        waitIdle(n, stable);
        checks++; if (n != DIV_N) begin errors++; $display("[TB] FAIL divzero_cycles: got %0d expected %0d", n, DIV_N); end
        checks++; if (hi !== 32'h11) begin errors++; $display("[TB] FAIL divzero_hi: got %h expected 00000011", hi); end
        checks++; if (lo !== 32'h22) begin errors++; $display("[TB] FAIL divzero_lo: got %h expected 00000022", lo); end
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        waitIdle(n, stable);
        checks++; if (lo !== 32'h80000000) begin errors++; $display("[TB] FAIL divovf_lo: got %h expected 80000000", lo); end
        checks++; if (hi !== 32'd0) begin errors++; $display("[TB] FAIL divovf_hi: got %h expected 00000000", hi); end
        modelHi = 32'd0;
        modelLo = 32'h80000000;
    endtask

    task automatic test_moves();
        issue(3'd4, 32'hDEADBEEF, 32'd0);
        checks++; if (hi !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL mthi_hi: got %h expected deadbeef", hi); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mthi_busy: got %b expected 0", busy); end
        checks++; if (lo !== modelLo) begin errors++; $display("[TB] FAIL mthi_lo: got %h expected %h", lo, modelLo); end
        modelHi = 32'hDEADBEEF;
        issue(3'd5, 32'hCAFEF00D, 32'd0);
        checks++; if (lo !== 32'hCAFEF00D) begin errors++; $display("[TB] FAIL mtlo_lo: got %h expected cafef00d", lo); end
        modelLo = 32'hCAFEF00D;
    endtask

    task automatic test_back_to_back();
        logic [31:0] eh;
        logic [31:0] el;
        int          cyc;
        int          n;
        logic        stable;
        modelOp(3'd0, 32'd123456, 32'hFFFFFCEB, eh, el, cyc);
        issue(3'd0, 32'd123456, 32'hFFFFFCEB);
        issue(3'd4, 32'h0BAD0BAD, 32'd0);
        issue(3'd2, 32'd100, 32'd3);
        waitIdle(n, stable);
        checks++; if (n != MULT_N - 2) begin errors++; $display("[TB] FAIL overlap_cycles: got %0d expected %0d", n, MULT_N - 2); end
        checks++; if (!stable) begin errors++; $display("[TB] FAIL overlap_hold: hi/lo changed while busy"); end
        checks++; if (hi !== eh) begin errors++; $display("[TB] FAIL overlap_hi: got %h expected %h", hi, eh); end
        checks++; if (lo !== el) begin errors++; $display("[TB] FAIL overlap_lo: got %h expected %h", lo, el); end
        modelHi = eh;
        modelLo = el;
        repeat (12) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL overlap_noqueue_busy: got %b expected 0", busy); end
        checks++; if (hi !== eh || lo !== el) begin errors++; $display("[TB] FAIL overlap_noqueue_hilo: got %h/%h expected %h/%h", hi, lo, eh, el); end
    endtask

    task automatic test_madd();
        int   n;
        logic stable;
        issue(3'd4, 32'd0, 32'd0);
        issue(3'd5, 32'hFFFFFFFF, 32'd0);
        modelHi = 32'd0;
        modelLo = 32'hFFFFFFFF;
`ifdef MDU_MADD_EN
        issue(3'd7, 32'd1, 32'd1);
        waitIdle(n, stable);
        checks++; if (n != MULT_N) begin errors++; $display("[TB] FAIL maddu_cycles: got %0d expected %0d", n, MULT_N); end
        checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("[TB] FAIL maddu_hilo: got %h/%h expected 00000001/00000000", hi, lo); end
        modelHi = 32'd1;
        modelLo = 32'd0;
        issue(3'd6, 32'hFFFFFFFF, 32'd1);
        waitIdle(n, stable);
        checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL madd_hilo: got %h/%h expected 00000000/ffffffff", hi, lo); end
        modelHi = 32'd0;
        modelLo = 32'hFFFFFFFF;
`else
        issue(3'd6, 32'd5, 32'd7);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL madd_off_busy: got %b expected 0", busy); end
        waitIdle(n, stable);
        repeat (6) @(posedge clk);
        #1;
        checks++; if (hi !== 32'd0 || lo !== 32'hFFFFFFFF) begin errors++; $display("[TB] FAIL madd_off_hilo: got %h/%h expected 00000000/ffffffff", hi, lo); end
`endif
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
        int          cyc;
        int          n;
        logic        stable;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            modelOp(op, a, b, eh, el, cyc);
            issue(op, a, b);
            waitIdle(n, stable);
            checks++; if (n != cyc) begin errors++; $display("[TB] FAIL rand_cycles[%0d] op%0d: got %0d expected %0d", i, op, n, cyc); end
            checks++; if (!stable) begin errors++; $display("[TB] FAIL rand_hold[%0d] op%0d: hi/lo changed while busy", i, op); end
            checks++; if (hi !== eh) begin errors++; $display("[TB] FAIL rand_hi[%0d] op%0d a=%h b=%h: got %h expected %h", i, op, a, b, hi, eh); end
            checks++; if (lo !== el) begin errors++; $display("[TB] FAIL rand_lo[%0d] op%0d a=%h b=%h: got %h expected %h", i, op, a, b, lo, el); end
            modelHi = hi;
            modelLo = lo;
            modelHi = eh;
            modelLo = el;
        end
    endtask

    task automatic test_reset_mid_div();
        int   n;
        logic stable;
        issue(3'd4, 32'h55, 32'd0);
        issue(3'd5, 32'h66, 32'd0);
        issue(3'd2, 32'd100, 32'd7);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL middiv_reset_busy: got %b expected 0", busy); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("[TB] FAIL middiv_reset_hilo: got %h/%h expected 0/0", hi, lo); end
        @(negedge clk);
        reset   = 1'b1;
        modelHi = 32'd0;
        modelLo = 32'd0;
        repeat (15) @(posedge clk);
        #1;
        waitIdle(n, stable);
        checks++; if (n != 0) begin errors++; $display("[TB] FAIL middiv_after_busy: got %0d busy cycles expected 0", n); end
        checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("[TB] FAIL middiv_after_hilo: got %h/%h expected 0/0", hi, lo); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        test_reset();
        test_mult();
        test_div();
        test_boundary_div();
        test_moves();
        test_back_to_back();
        test_madd();
        test_random();
        test_reset_mid_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
